dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/dcache.sv | 160 ++++++++++++++++
 tb/tb_dcache.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a word-serial
// refill from backing memory; hits return combinationally, misses and stores stall.
module dcache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  stall_o,
  output logic                  mem_rd_req_o,
  output logic                  mem_wr_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE);
  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int TAG_LSB     = 2 + OFFSET_BITS + INDEX_BITS;
  localparam int TAG_BITS    = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [SETS-1:0]         valid_r;
  logic [TAG_BITS-1:0]     tag_r  [SETS];
  logic [DATA_WIDTH-1:0]   line_r [SETS][WORDS_PER_LINE];
  logic [OFFSET_BITS-1:0]  count_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [ADDR_WIDTH-1:0]   wAddr_r;
  logic [DATA_WIDTH-1:0]   wData_r;

  logic [OFFSET_BITS-1:0]  offset_s;
  logic [INDEX_BITS-1:0]   index_s;
  logic [TAG_BITS-1:0]     tag_s;
  logic [INDEX_BITS-1:0]   baseIndex_s;
  logic [TAG_BITS-1:0]     baseTag_s;
  logic                    hit_s;
  logic                    lastAck_s;
  logic                    unusedByteBits_s;

  assign offset_s         = addr_i[OFFSET_BITS+1:2];
  assign index_s          = addr_i[TAG_LSB-1:OFFSET_BITS+2];
  assign tag_s            = addr_i[ADDR_WIDTH-1:TAG_LSB];
  assign baseIndex_s      = base_r[TAG_LSB-1:OFFSET_BITS+2];
  assign baseTag_s        = base_r[ADDR_WIDTH-1:TAG_LSB];
  assign hit_s            = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign lastAck_s        = (state_r == REFILL) && mem_ack_i &&
                            (count_r == OFFSET_BITS'(WORDS_PER_LINE - 1));
  assign unusedByteBits_s = ^addr_i[1:0];

  // Output decode: hit data, stall and memory request signals per state
  always_comb begin
    data_o       = '0;
    stall_o      = 1'b0;
    mem_rd_req_o = 1'b0;
    mem_wr_req_o = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_r)
      IDLE: begin
        if (wr_en_i) begin
          stall_o = 1'b1;
        end else if (rd_en_i && hit_s) begin
          data_o = line_r[index_s][offset_s];
        end else if (rd_en_i) begin
          stall_o = 1'b1;
        end else begin
          stall_o = 1'b0;
        end
      end
      REFILL: begin
        stall_o      = 1'b1;
        mem_rd_req_o = 1'b1;
        mem_addr_o   = {base_r[ADDR_WIDTH-1:OFFSET_BITS+2], count_r, 2'b00};
      end
      WRITE: begin
        mem_wr_req_o = 1'b1;
        mem_addr_o   = wAddr_r;
        mem_wdata_o  = wData_r;
        stall_o      = !mem_ack_i;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

  // Control FSM: valid bits, refill counter and latched request state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      valid_r <= '0;
      count_r <= '0;
      base_r  <= '0;
      wAddr_r <= '0;
      wData_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_en_i) begin
            wAddr_r <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            wData_r <= data_i;
            state_r <= WRITE;
          end else if (rd_en_i && !hit_s) begin
            // Invalidate up front so an abandoned refill never leaves a mixed line valid
            base_r           <= {addr_i[ADDR_WIDTH-1:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
            count_r          <= '0;
            valid_r[index_s] <= 1'b0;
            state_r          <= REFILL;
          end else begin
            state_r <= IDLE;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            count_r <= count_r + 1'b1;
            if (lastAck_s) begin
              valid_r[baseIndex_s] <= 1'b1;
              state_r              <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_ack_i) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage: refill words, final tag write, store-hit update
  always_ff @(posedge clk_i) begin
    if ((state_r == IDLE) && wr_en_i && hit_s) begin
      line_r[index_s][offset_s] <= data_i;
    end else if ((state_r == REFILL) && mem_ack_i) begin
      line_r[baseIndex_s][count_r] <= mem_rdata_i;
      if (lastAck_s) begin
        tag_r[baseIndex_s] <= baseTag_s;
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: refill sequencing, hits, write-through stores,
// conflict eviction and reset abandoning an in-flight refill.
module tb_dcache;

  logic        clk_i = 1'b0;
  logic        rst_i, rd_en_i, wr_en_i, mem_ack_i;
  logic [31:0] addr_i, data_i, mem_rdata_i;
  logic [31:0] data_o, mem_addr_o, mem_wdata_o;
  logic        stall_o, mem_rd_req_o, mem_wr_req_o;

  int nCmp = 0;
  int nErr = 0;

  dcache dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_wr_req_o(mem_wr_req_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Acks four refill words back to back starting at d0; leaves the bench in the
  // cycle after the final ack with ack dropped.
  task automatic serve_refill(input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack_i   = 1'b1;
      mem_rdata_i = d0 + 32'(i);
    end
    step();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rd_en_i = 1'b0; wr_en_i = 1'b0; mem_ack_i = 1'b0;
    addr_i = 32'h0; data_i = 32'h0; mem_rdata_i = 32'h0;
    step(); step();
    rst_i = 1'b0;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b0) begin nErr++; $display("FAIL reset_stall got %b want 0", stall_o); end
    nCmp++; if (mem_rd_req_o !== 1'b0 || mem_wr_req_o !== 1'b0) begin nErr++; $display("FAIL reset_req got %b%b want 00", mem_rd_req_o, mem_wr_req_o); end
    nCmp++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || data_o !== 32'h0) begin nErr++; $display("FAIL reset_data got %h %h %h want 0", mem_addr_o, mem_wdata_o, data_o); end
  endtask

  task automatic test_read_miss();
    int stallCnt = 0;
    step();
    rd_en_i = 1'b1; addr_i = 32'h100;
    @(negedge clk_i);
    if (stall_o === 1'b1) stallCnt++;
    nCmp++; if (stall_o !== 1'b1 || mem_rd_req_o !== 1'b0) begin nErr++; $display("FAIL miss_issue got stall=%b rd=%b want 1 0", stall_o, mem_rd_req_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 32'hA0 + 32'(i);
      @(negedge clk_i);
      if (stall_o === 1'b1) stallCnt++;
      nCmp++; if (mem_rd_req_o !== 1'b1 || mem_wr_req_o !== 1'b0 || mem_addr_o !== 32'h100 + 32'(4 * i)) begin
        nErr++; $display("FAIL refill_word%0d got rd=%b wr=%b addr=%h want 1 0 %h", i, mem_rd_req_o, mem_wr_req_o, mem_addr_o, 32'h100 + 32'(4 * i));
      end
    end
    step();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    if (stall_o === 1'b1) stallCnt++;
    nCmp++; if (stallCnt != 5) begin nErr++; $display("FAIL miss_latency got %0d want 5", stallCnt); end
    nCmp++; if (data_o !== 32'hA0 || stall_o !== 1'b0 || mem_rd_req_o !== 1'b0) begin nErr++; $display("FAIL miss_then_hit got %h stall=%b want a0 0", data_o, stall_o); end
  endtask

  task automatic test_read_hit();
    step();
    addr_i = 32'h108;
    @(negedge clk_i);
    nCmp++; if (data_o !== 32'hA2 || stall_o !== 1'b0 || mem_rd_req_o !== 1'b0 || mem_wr_req_o !== 1'b0) begin
      nErr++; $display("FAIL read_hit got %h stall=%b rd=%b wr=%b want a2 0 0 0", data_o, stall_o, mem_rd_req_o, mem_wr_req_o);
    end
  endtask

  task automatic test_store_hit();
    step();
    rd_en_i = 1'b0; wr_en_i = 1'b1; addr_i = 32'h104; data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1 || mem_wr_req_o !== 1'b0) begin nErr++; $display("FAIL store_issue got stall=%b wr=%b want 1 0", stall_o, mem_wr_req_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ack_i = (i == 2) ? 1'b1 : 1'b0;
      @(negedge clk_i);
      nCmp++; if (mem_wr_req_o !== 1'b1 || mem_rd_req_o !== 1'b0 || mem_addr_o !== 32'h104 || mem_wdata_o !== 32'hDEADBEEF || stall_o !== (i != 2)) begin
        nErr++; $display("FAIL store_wait%0d got wr=%b rd=%b addr=%h wd=%h stall=%b", i, mem_wr_req_o, mem_rd_req_o, mem_addr_o, mem_wdata_o, stall_o);
      end
    end
    step();
    mem_ack_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b1; data_i = 32'h0;
    @(negedge clk_i);
    nCmp++; if (data_o !== 32'hDEADBEEF || stall_o !== 1'b0 || mem_wr_req_o !== 1'b0) begin
      nErr++; $display("FAIL store_hit_read got %h stall=%b wr=%b want deadbeef 0 0", data_o, stall_o, mem_wr_req_o);
    end
  endtask

  task automatic test_conflict();
    step();
    addr_i = 32'h200;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1) begin nErr++; $display("FAIL conflict_miss got stall=%b want 1", stall_o); end
    serve_refill(32'hB0);
    @(negedge clk_i);
    nCmp++; if (data_o !== 32'hB0 || stall_o !== 1'b0) begin nErr++; $display("FAIL conflict_fill got %h want b0", data_o); end
    step();
    addr_i = 32'h100;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1 || data_o !== 32'h0) begin nErr++; $display("FAIL evicted_miss got stall=%b data=%h want 1 0", stall_o, data_o); end
    serve_refill(32'hC0);
    @(negedge clk_i);
    nCmp++; if (data_o !== 32'hC0 || stall_o !== 1'b0) begin nErr++; $display("FAIL refetch got %h want c0", data_o); end
  endtask

  task automatic test_both_is_store();
    step();
    wr_en_i = 1'b1; addr_i = 32'h10C; data_i = 32'h55;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1 || data_o !== 32'h0 || mem_rd_req_o !== 1'b0) begin nErr++; $display("FAIL both_issue got stall=%b data=%h want 1 0", stall_o, data_o); end
    step();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    nCmp++; if (mem_wr_req_o !== 1'b1 || mem_rd_req_o !== 1'b0 || mem_addr_o !== 32'h10C || mem_wdata_o !== 32'h55) begin
      nErr++; $display("FAIL both_write got wr=%b rd=%b addr=%h wd=%h", mem_wr_req_o, mem_rd_req_o, mem_addr_o, mem_wdata_o);
    end
    step();
    mem_ack_i = 1'b0; wr_en_i = 1'b0;
    @(negedge clk_i);
    nCmp++; if (data_o !== 32'h55 || stall_o !== 1'b0) begin nErr++; $display("FAIL both_readback got %h want 55", data_o); end
  endtask

  task automatic test_reset_refill();
    step();
    addr_i = 32'h200;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1) begin nErr++; $display("FAIL rr_miss got stall=%b want 1", stall_o); end
    for (int i = 0; i < 2; i++) begin
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 32'hE0 + 32'(i);
    end
    step();
    mem_ack_i = 1'b0; rst_i = 1'b1; rd_en_i = 1'b0;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    nCmp++; if (mem_rd_req_o !== 1'b0 || mem_wr_req_o !== 1'b0 || stall_o !== 1'b0) begin nErr++; $display("FAIL rr_abandon got rd=%b wr=%b stall=%b want 0", mem_rd_req_o, mem_wr_req_o, stall_o); end
    step();
    rd_en_i = 1'b1; addr_i = 32'h100;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1 || data_o !== 32'h0) begin nErr++; $display("FAIL rr_old_line got stall=%b data=%h want 1 0", stall_o, data_o); end
    step();
    rd_en_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0; rd_en_i = 1'b1; addr_i = 32'h200;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1 || data_o !== 32'h0) begin nErr++; $display("FAIL rr_partial_line got stall=%b data=%h want 1 0", stall_o, data_o); end
    step();
    rd_en_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_store_miss();
    step();
    wr_en_i = 1'b1; addr_i = 32'h300; data_i = 32'h12345678;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1) begin nErr++; $display("FAIL sm_issue got stall=%b want 1", stall_o); end
    step();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    nCmp++; if (mem_wr_req_o !== 1'b1 || mem_rd_req_o !== 1'b0 || mem_addr_o !== 32'h300 || mem_wdata_o !== 32'h12345678 || stall_o !== 1'b0) begin
      nErr++; $display("FAIL sm_write got wr=%b rd=%b addr=%h wd=%h stall=%b", mem_wr_req_o, mem_rd_req_o, mem_addr_o, mem_wdata_o, stall_o);
    end
    step();
    mem_ack_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b1;
    @(negedge clk_i);
    nCmp++; if (stall_o !== 1'b1 || data_o !== 32'h0 || mem_wr_req_o !== 1'b0) begin nErr++; $display("FAIL sm_no_alloc got stall=%b data=%h wr=%b want 1 0 0", stall_o, data_o, mem_wr_req_o); end
    step();
    rd_en_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_hit();
    test_conflict();
    test_both_is_store();
    test_reset_refill();
    test_store_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
